// File: rtl/trireg_keeper_bank.sv
// trireg_keeper_bank
//   Multi-channel charge-storage keeper. Each channel captures its drive data
//   while drv_en is high, keeps that value after the driver releases, and
//   decays to DECAY_VALUE once a strength-dependent hold limit runs out.
//   Strength 11 keeps the value until a discharge or reset. A global
//   discharge clears every channel that is not being driven on that edge.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   drv_en       per-channel drive enable (bit i -> channel i)
//   drv_data     per-channel drive data, channel i at [i*WIDTH +: WIDTH]
//   strength     per-channel strength, channel i at [i*2 +: 2]
//                (00 small, 01 medium, 10 large, 11 hold-forever)
//   discharge    global discharge request, sampled each edge
//   q            kept value per channel (registered)
//   valid        channel is DRIVEN or HOLD (registered)
//   decay_pulse  one-cycle pulse when a channel decays by timeout
//   valid_count  population count of valid (registered)
module trireg_keeper_bank #(
  parameter int NCH          = 4,
  parameter int WIDTH        = 16,
  parameter int DECAY_CYCLES = 50,
  parameter int DECAY_VALUE  = 0,
  parameter int CNT_W        = $clog2(DECAY_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             drv_en,
  input  logic [NCH*WIDTH-1:0]       drv_data,
  input  logic [NCH*2-1:0]           strength,
  input  logic                       discharge,
  output logic [NCH*WIDTH-1:0]       q,
  output logic [NCH-1:0]             valid,
  output logic [NCH-1:0]             decay_pulse,
  output logic [$clog2(NCH+1)-1:0]   valid_count
);

  localparam int VC_W = $clog2(NCH + 1);

  localparam int L_SMALL_I = ((DECAY_CYCLES >> 2) < 1) ? 1 : (DECAY_CYCLES >> 2);
  localparam int L_MED_I   = ((DECAY_CYCLES >> 1) < 1) ? 1 : (DECAY_CYCLES >> 1);

  localparam logic [CNT_W-1:0] L_SMALL = CNT_W'(L_SMALL_I);
  localparam logic [CNT_W-1:0] L_MED   = CNT_W'(L_MED_I);
  localparam logic [CNT_W-1:0] L_LARGE = CNT_W'(DECAY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] DV      = WIDTH'(DECAY_VALUE);

  typedef enum logic [1:0] {
    ST_DECAYED = 2'd0,
    ST_DRIVEN  = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t           state     [NCH];
  state_t           state_nxt [NCH];
  logic [CNT_W-1:0] cnt       [NCH];
  logic [CNT_W-1:0] cnt_nxt   [NCH];
  logic [1:0]       str       [NCH];
  logic [1:0]       str_nxt   [NCH];

  logic [NCH*WIDTH-1:0] q_nxt;
  logic [NCH-1:0]       valid_nxt;
  logic [NCH-1:0]       pulse_nxt;
  logic [VC_W-1:0]      vc_nxt;

  // Strength 11 never reaches this function's result; it is handled separately.
  function automatic logic [CNT_W-1:0] hold_limit(input logic [1:0] s);
    case (s)
      2'b00:   return L_SMALL;
      2'b01:   return L_MED;
      default: return L_LARGE;
    endcase
  endfunction

  always_comb begin
    q_nxt     = q;
    valid_nxt = valid;
    pulse_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      str_nxt[i]   = str[i];
      if (drv_en[i]) begin
        // Drive wins over discharge and over an expiring timeout.
        q_nxt[i*WIDTH +: WIDTH] = drv_data[i*WIDTH +: WIDTH];
        state_nxt[i] = ST_DRIVEN;
        cnt_nxt[i]   = '0;
        str_nxt[i]   = strength[i*2 +: 2];
        valid_nxt[i] = 1'b1;
      end else if (discharge) begin
        q_nxt[i*WIDTH +: WIDTH] = DV;
        state_nxt[i] = ST_DECAYED;
        cnt_nxt[i]   = '0;
        valid_nxt[i] = 1'b0;
      end else begin
        case (state[i])
          ST_DRIVEN: begin
            state_nxt[i] = ST_HOLD;
            cnt_nxt[i]   = CNT_W'(1);
          end
          ST_HOLD: begin
            if (str[i] == 2'b11) begin
              // Saturate so the counter never wraps back into a decay.
              if (cnt[i] != CNT_MAX) cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end else if (cnt[i] >= hold_limit(str[i])) begin
              q_nxt[i*WIDTH +: WIDTH] = DV;
              state_nxt[i] = ST_DECAYED;
              cnt_nxt[i]   = '0;
              valid_nxt[i] = 1'b0;
              pulse_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state_nxt[i] = ST_DECAYED;
          end
        endcase
      end
    end
  end

  always_comb begin
    vc_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      vc_nxt = vc_nxt + VC_W'(valid_nxt[i]);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= ST_DECAYED;
        cnt[i]   <= '0;
        str[i]   <= 2'b10;
      end
      q           <= {NCH{DV}};
      valid       <= '0;
      decay_pulse <= '0;
      valid_count <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        str[i]   <= str_nxt[i];
      end
      q           <= q_nxt;
      valid       <= valid_nxt;
      decay_pulse <= pulse_nxt;
      valid_count <= vc_nxt;
    end
  end

endmodule

// File: tb/tb_trireg_keeper_bank.sv
// Testbench for trireg_keeper_bank (NCH=4, WIDTH=16, DECAY_CYCLES=8,
// DECAY_VALUE=0). Stimulus pushes hand-computed expected outputs into a
// queue; a monitor pops one entry per falling edge (or on an explicit
// trigger for mid-cycle checks) and compares it with the DUT outputs.
module tb_trireg_keeper_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int DC    = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       drv_en;
  logic [NCH*WIDTH-1:0] drv_data;
  logic [NCH*2-1:0]     strength;
  logic                 discharge;
  logic [NCH*WIDTH-1:0] q;
  logic [NCH-1:0]       valid;
  logic [NCH-1:0]       decay_pulse;
  logic [2:0]           valid_count;

  always #5 clk = ~clk;

  trireg_keeper_bank #(
    .NCH(NCH), .WIDTH(WIDTH), .DECAY_CYCLES(DC), .DECAY_VALUE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data),
    .strength(strength), .discharge(discharge), .q(q), .valid(valid),
    .decay_pulse(decay_pulse), .valid_count(valid_count)
  );

  typedef struct {
    string       name;
    int          ch;
    logic [15:0] q;
    logic [3:0]  v;
    logic [3:0]  p;
    logic [2:0]  vc;
  } exp_t;

  exp_t exp_q[$];
  event mon_ev;
  int   tests = 0;
  int   fails = 0;

  // Monitor: compares the oldest expectation with the DUT outputs.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [15:0] qa;
        e  = exp_q.pop_front();
        qa = q[e.ch*WIDTH +: WIDTH];
        tests++;
        if (qa !== e.q || valid !== e.v || decay_pulse !== e.p || valid_count !== e.vc) begin
          fails++;
          $display("FAIL %s ch%0d: got q=%h valid=%b pulse=%b vc=%0d, want q=%h valid=%b pulse=%b vc=%0d",
                   e.name, e.ch, qa, valid, decay_pulse, valid_count, e.q, e.v, e.p, e.vc);
        end
      end
    end
  end

  task automatic push(input string name, input int ch, input logic [15:0] eq,
                      input logic [3:0] ev, input logic [3:0] ep, input logic [2:0] evc);
    exp_t e;
    e.name = name; e.ch = ch; e.q = eq; e.v = ev; e.p = ep; e.vc = evc;
    exp_q.push_back(e);
  endtask

  // Expect the given outputs after the next rising edge.
  task automatic tick(input string name, input int ch, input logic [15:0] eq,
                      input logic [3:0] ev, input logic [3:0] ep, input logic [2:0] evc);
    push(name, ch, eq, ev, ep, evc);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [15:0] d, input logic [1:0] s);
    drv_en[ch]                  = 1'b1;
    drv_data[ch*WIDTH +: WIDTH] = d;
    strength[ch*2 +: 2]         = s;
  endtask

  initial begin
    rst_n = 1'b0; drv_en = '0; drv_data = '0; strength = '0; discharge = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tick("reset", 0, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    rst_n = 1'b1;

    // Large hold: 8 cycles of BEEF, decay on the 9th edge.
    drive(0, 16'hBEEF, 2'b10);
    tick("large_drive", 0, 16'hBEEF, 4'b0001, 4'b0000, 3'd1);
    drv_en = '0;
    for (int k = 1; k <= 8; k++) tick("large_hold", 0, 16'hBEEF, 4'b0001, 4'b0000, 3'd1);
    tick("large_decay", 0, 16'h0000, 4'b0000, 4'b0001, 3'd0);
    tick("large_after", 0, 16'h0000, 4'b0000, 4'b0000, 3'd0);

    // Strength scaling on ch1/ch2/ch3.
    drive(1, 16'h1111, 2'b00);
    drive(2, 16'h2222, 2'b01);
    drive(3, 16'h3333, 2'b11);
    tick("scale_drive", 1, 16'h1111, 4'b1110, 4'b0000, 3'd3);
    drv_en = '0;
    tick("scale_h1", 1, 16'h1111, 4'b1110, 4'b0000, 3'd3);
    tick("scale_h2", 1, 16'h1111, 4'b1110, 4'b0000, 3'd3);
    tick("scale_ch1_decay", 1, 16'h0000, 4'b1100, 4'b0010, 3'd2);
    tick("scale_h4", 2, 16'h2222, 4'b1100, 4'b0000, 3'd2);
    tick("scale_ch2_decay", 2, 16'h0000, 4'b1000, 4'b0100, 3'd1);
    idle(1000);
    tick("scale_ch3_forever", 3, 16'h3333, 4'b1000, 4'b0000, 3'd1);

    // Refresh on hold cycle 7 and on the exact expiry edge.
    drive(0, 16'hBEEF, 2'b10);
    tick("refresh_drive", 0, 16'hBEEF, 4'b1001, 4'b0000, 3'd2);
    drv_en = '0;
    for (int k = 1; k <= 6; k++) tick("refresh_hold_a", 0, 16'hBEEF, 4'b1001, 4'b0000, 3'd2);
    drive(0, 16'h1234, 2'b10);
    tick("refresh_edge7", 0, 16'h1234, 4'b1001, 4'b0000, 3'd2);
    drv_en = '0;
    for (int k = 1; k <= 8; k++) tick("refresh_hold_b", 0, 16'h1234, 4'b1001, 4'b0000, 3'd2);
    drive(0, 16'h5678, 2'b10);
    tick("refresh_expiry", 0, 16'h5678, 4'b1001, 4'b0000, 3'd2);
    drv_en = '0;
    tick("refresh_rel1", 0, 16'h5678, 4'b1001, 4'b0000, 3'd2);
    tick("refresh_rel2", 0, 16'h5678, 4'b1001, 4'b0000, 3'd2);

    // Discharge with ch0/ch3 in HOLD while ch1 is driven.
    drive(1, 16'hAAAA, 2'b10);
    discharge = 1'b1;
    tick("discharge_ch1", 1, 16'hAAAA, 4'b0010, 4'b0000, 3'd1);
    discharge = 1'b0;
    drv_en    = '0;
    tick("discharge_ch0", 0, 16'h0000, 4'b0010, 4'b0000, 3'd1);
    tick("discharge_ch3", 3, 16'h0000, 4'b0010, 4'b0000, 3'd1);
    discharge = 1'b1;
    tick("discharge_hold", 1, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    discharge = 1'b0;

    // Strength change during HOLD is ignored.
    drive(0, 16'hCAFE, 2'b10);
    tick("strchg_drive", 0, 16'hCAFE, 4'b0001, 4'b0000, 3'd1);
    drv_en        = '0;
    strength[1:0] = 2'b00;
    for (int k = 1; k <= 8; k++) tick("strchg_hold", 0, 16'hCAFE, 4'b0001, 4'b0000, 3'd1);
    tick("strchg_decay", 0, 16'h0000, 4'b0000, 4'b0001, 3'd0);
    tick("strchg_after", 0, 16'h0000, 4'b0000, 4'b0000, 3'd0);

    // Asynchronous reset in the middle of hold cycle 3.
    drive(0, 16'h0F0F, 2'b10);
    tick("arst_drive", 0, 16'h0F0F, 4'b0001, 4'b0000, 3'd1);
    drv_en = '0;
    for (int k = 1; k <= 3; k++) tick("arst_hold", 0, 16'h0F0F, 4'b0001, 4'b0000, 3'd1);
    #1;
    rst_n = 1'b0;
    #1;
    push("arst_immediate", 0, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    -> mon_ev;
    @(negedge clk);
    #1;
    tick("arst_held", 0, 16'h0000, 4'b0000, 4'b0000, 3'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) tick("arst_after", 0, 16'h0000, 4'b0000, 4'b0000, 3'd0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trireg_keeper_bank.md
Name: trireg_keeper_bank

Overview:
- Parametrised, synthesizable multi-channel charge-storage keeper.
- Each channel holds the last driven value after its driver releases, then decays to a fixed value after a strength-dependent timeout.
- Generalises the single-node trireg charge-decay model to NCH channels of WIDTH bits, with per-channel strength selection, a no-decay mode and a global discharge.
- Sits between tri-state-style bus drivers and downstream consumers in the interconnect layer.

Parameters:
- NCH, 4, number of independent channels.
- WIDTH, 16, data bits per channel.
- DECAY_CYCLES, 50, hold time in cycles for strength "large"; must be at least 1.
- DECAY_VALUE, 0, value a channel's q takes when decayed, truncated to WIDTH.
- CNT_W, $clog2(DECAY_CYCLES+1), hold counter width; derived, do not override.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- drv_en  input  NCH  per-channel drive enable; bit i drives channel i.
- drv_data  input  NCH*WIDTH  per-channel drive data; channel i occupies [i*WIDTH +: WIDTH].
- strength  input  NCH*2  per-channel strength: 00 small, 01 medium, 10 large, 11 hold-forever.
- discharge  input  1  global discharge request, level-sensitive and sampled each edge.
- q  output  NCH*WIDTH  kept value per channel.
- valid  output  NCH  1 while the channel is DRIVEN or HOLD.
- decay_pulse  output  NCH  one-cycle pulse on the edge a channel decays by timeout.
- valid_count  output  $clog2(NCH+1)  population count of valid, registered.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - every channel enters DECAYED;
  - q = DECAY_VALUE, valid = 0, decay_pulse = 0, valid_count = 0;
  - hold counters = 0, latched strength = 10.
- Channel states: DECAYED, DRIVEN, HOLD. Channels are fully independent; only discharge is shared.
- Hold limit L, computed from the latched strength:
  - 00 → max(1, DECAY_CYCLES>>2);
  - 01 → max(1, DECAY_CYCLES>>1);
  - 10 → DECAY_CYCLES;
  - 11 → no limit.
- Strength latching:
  - strength[i] is latched on every edge where drv_en[i]=1.
  - Strength changes while the channel is in HOLD are ignored.
- Any state, drv_en[i]=1 at an edge:
  - q_i <= drv_data_i, state DRIVEN, counter cleared, valid_i = 1.
  - Latency is 1 cycle.
  - drv_en takes priority over discharge and over an expiring timeout.
- DRIVEN with drv_en[i]=0 → HOLD, counter <= 1. q_i is unchanged.
- HOLD with drv_en[i]=0:
  - counter < L: counter increments, q_i is held.
  - counter == L: state DECAYED, q_i <= DECAY_VALUE, valid_i <= 0, decay_pulse_i = 1 for exactly one cycle.
  - Net effect: q_i stays at the driven value for exactly L cycles after the last driven edge.
  - Strength 11: the counter saturates at its maximum value and never decays.
- DECAYED with drv_en[i]=0: remains DECAYED, no pulse.
- discharge=1 at an edge:
  - every channel with drv_en[i]=0 goes to DECAYED, q_i = DECAY_VALUE, valid_i = 0;
  - no decay_pulse is raised;
  - this applies to strength 11 channels too.
- Simultaneous events:
  - timeout expiry and discharge on the same edge: discharge wins, so no pulse;
  - timeout expiry and drv_en on the same edge: drv_en wins, so no pulse.
- valid_count is registered from the next-state valid vector, so it updates on the same edge as valid.
- Reset asserted mid-hold takes effect immediately and asynchronously; no pulse is emitted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan (NCH=4, WIDTH=16, DECAY_CYCLES=8, DECAY_VALUE=16'h0000):
- Large hold: drive ch0 = 16'hBEEF, strength 10, for 1 cycle, then release.
  - q0 = BEEF for 8 cycles after the drive edge.
  - On the 9th edge, q0 = 0000, valid0 = 0, decay_pulse0 = 1 for one cycle.
- Strength scaling: drive ch1 (strength 00), ch2 (01) and ch3 (11) with 1111/2222/3333 on the same cycle, then release.
  - ch1 decays after 2 cycles, ch2 after 4 cycles.
  - ch3 still holds 3333 after 1000 cycles.
  - valid_count steps 3 → 2 → 1.
- Refresh: re-drive ch0 on hold cycle 7 with 16'h1234, then release.
  - No pulse occurs.
  - q0 = 1234 and the 8-cycle hold restarts.
  - Re-driving on the exact expiry edge also yields no pulse.
- Discharge: ch0 and ch3 in HOLD, ch1 driven with 16'hAAAA, discharge=1 for 1 cycle.
  - ch0 and ch3 go to DECAYED with no pulses.
  - ch1 = AAAA, valid1 = 1, valid_count = 1.
- Strength change in HOLD: drive ch0 with strength 10, release, switch strength to 00 during HOLD → ch0 still decays after 8 cycles.
- Async reset: assert rst_n=0 at hold cycle 3, between clock edges.
  - All q = 0000, valid = 0 immediately.
  - No decay_pulse before or after release.
